// File: rtl/noc_pkg.sv
// Shared NoC definitions for the router crossbar.
//   flit_type_e    : two-bit flit type carried in the top bits of every flit
//   FLIT_TYPE_W    : width of that type field
//   flit_type()    : decode a type field into flit_type_e
//   is_packet_start: true for flits that may open a transfer on a free output
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  localparam int FLIT_TYPE_W = 2;

  // The type field sits at [FLIT_WIDTH-1 -: FLIT_TYPE_W]; callers slice it
  // out so the helpers stay independent of the flit width.
  function automatic flit_type_e flit_type(input logic [FLIT_TYPE_W-1:0] type_field);
    return flit_type_e'(type_field);
  endfunction

  function automatic logic is_packet_start(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/rr_switch_crossbar_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a rotating priority pointer.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   req      : request vector
//   advance  : the current grant was used; move the pointer past the winner
//   gnt      : one-hot grant (zero when no request is present)
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  // Search starts at ptr and wraps; the first requester found wins.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx] && !found) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_next = PW'((idx + 1) % N);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/rr_switch_crossbar.sv
// rr_switch_crossbar: registered PORT_NUM x PORT_NUM wormhole crossbar with
// per-output round-robin switch allocation.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : per-input flit present
//   in_flit   : per-input flit data, type in the top two bits
//   in_dest   : per-input one-hot output request
//   in_ready  : per-input flit consumed this cycle
//   out_valid : per-output register holds a flit
//   out_flit  : per-output register data
//   out_ready : per-output downstream accepts
module rr_switch_crossbar
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 76,
  parameter int PORT_NUM   = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [PORT_NUM-1:0]                  in_valid,
  input  logic [PORT_NUM-1:0][FLIT_WIDTH-1:0]  in_flit,
  input  logic [PORT_NUM-1:0][PORT_NUM-1:0]    in_dest,
  output logic [PORT_NUM-1:0]                  in_ready,
  output logic [PORT_NUM-1:0]                  out_valid,
  output logic [PORT_NUM-1:0][FLIT_WIDTH-1:0]  out_flit,
  input  logic [PORT_NUM-1:0]                  out_ready
);

  // req_to[o][i]: input i presents a flit for output o with a legal route.
  logic [PORT_NUM-1:0] req_to   [PORT_NUM];
  logic [PORT_NUM-1:0] in_start;
  // used_by[o][i]: output o consumes input i's flit this cycle.
  logic [PORT_NUM-1:0] used_by  [PORT_NUM];

  always_comb begin
    in_start = '0;
    for (int o = 0; o < PORT_NUM; o++) req_to[o] = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      in_start[i] = is_packet_start(flit_type(in_flit[i][FLIT_WIDTH-1 -: FLIT_TYPE_W]));
      // A non-one-hot destination is treated as requesting nothing.
      if (in_valid[i] && $onehot(in_dest[i])) begin
        for (int o = 0; o < PORT_NUM; o++) req_to[o][i] = in_dest[i][o];
      end
    end
  end

  // Destinations are one-hot, so each input appears in at most one used_by.
  always_comb begin
    in_ready = '0;
    for (int o = 0; o < PORT_NUM; o++) in_ready = in_ready | used_by[o];
  end

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_in_chk
    a_dest_onehot : assert property (@(posedge clk) disable iff (rst)
      in_valid[i] |-> $onehot(in_dest[i]));
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    logic                  locked;
    logic [PORT_NUM-1:0]   owner;      // one-hot owning input while locked
    logic [PORT_NUM-1:0]   cand;
    logic [PORT_NUM-1:0]   arb_gnt;
    logic [PORT_NUM-1:0]   gnt;
    logic                  acc;
    logic                  xfer;
    logic [FLIT_WIDTH-1:0] mux_flit;
    flit_type_e            mux_type;
    logic                  ov;
    logic [FLIT_WIDTH-1:0] of;

    // Only packet starts compete for a free output; once locked, the
    // arbiter is bypassed and the owner has exclusive use of any flit type.
    assign cand = locked ? '0 : (req_to[o] & in_start);
    assign gnt  = locked ? (owner & req_to[o]) : arb_gnt;
    assign acc  = !ov || out_ready[o];
    assign xfer = acc && (|gnt);

    assign used_by[o] = acc ? gnt : '0;

    rr_arbiter #(.N(PORT_NUM)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (cand),
      .advance (xfer && !locked),
      .gnt     (arb_gnt)
    );

    // One-hot AND-OR select of the granted input.
    always_comb begin
      mux_flit = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        mux_flit = mux_flit | ({FLIT_WIDTH{gnt[i]}} & in_flit[i]);
      end
      mux_type = flit_type(mux_flit[FLIT_WIDTH-1 -: FLIT_TYPE_W]);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ov     <= 1'b0;
        of     <= '0;
        locked <= 1'b0;
        owner  <= '0;
      end else begin
        if (xfer) begin
          ov <= 1'b1;
          of <= mux_flit;
          // While locked only the owner can transfer, so a TAIL here always
          // belongs to the owner; a free output never grants BODY/TAIL.
          case (mux_type)
            FLIT_HEAD: begin
              locked <= 1'b1;
              owner  <= gnt;
            end
            FLIT_TAIL: locked <= 1'b0;
            default:   ;
          endcase
        end else if (out_ready[o]) begin
          ov <= 1'b0;   // drained; data is left in place
        end
      end
    end

    assign out_valid[o] = ov;
    assign out_flit[o]  = of;
  end

endmodule
